// File: rtl/seq_adder_if.sv
// seq_adder_if: start/busy/done handshake plus operand and result bus for
// the digit-serial adder. The master issues requests; the slave computes.
interface seq_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/seq_adder.sv
// seq_adder: digit-serial adder. Adds a + b + cin DIGIT bits per clock,
// carrying between digits through a register, and publishes sum, carry-out
// and two's-complement overflow once all WIDTH/DIGIT digits are done.
// Results stay frozen during an operation and only update on completion.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  seq_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic             msb_a;
  logic             msb_b;
  logic [CNT_W-1:0] cnt;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] psum_nxt;

  // One digit of unsigned addition; the top bit is the digit carry-out.
  function automatic logic [DIGIT:0] digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(
    input logic ma,
    input logic mb,
    input logic ms
  );
    return (ma == mb) && (ms != ma);
  endfunction

  // Current digit sum and the partial sum with that digit inserted at the top,
  // so after STEPS insertions the first digit has reached bit 0.
  always_comb begin
    dsum     = digit_add(opa[DIGIT-1:0], opb[DIGIT-1:0], carry);
    psum_nxt = (psum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Control FSM with operand shifters, carry register and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa    <= bus.a;
            opb    <= bus.b;
            carry  <= bus.cin;
            msb_a  <= bus.a[WIDTH-1];
            msb_b  <= bus.b[WIDTH-1];
            psum   <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          psum  <= psum_nxt;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_r  <= psum_nxt;
            cout_r <= dsum[DIGIT];
            ovf_r  <= signed_ovf(msb_a, msb_b, psum_nxt[WIDTH-1]);
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: drives four seq_adder builds (DIGIT = 1, 2, 4, 8 at WIDTH = 8)
// from one stimulus stream and checks them against a plain-arithmetic model.
module tb_seq_adder;

  localparam int W      = 8;
  localparam int NI     = 4;
  localparam int MAXLAT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;

  int n_tests = 0;
  int n_fail  = 0;

  seq_adder_if #(.WIDTH(W)) if1 ();
  seq_adder_if #(.WIDTH(W)) if2 ();
  seq_adder_if #(.WIDTH(W)) if4 ();
  seq_adder_if #(.WIDTH(W)) if8 ();

  seq_adder #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  seq_adder #(.WIDTH(W), .DIGIT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  seq_adder #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  seq_adder #(.WIDTH(W), .DIGIT(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

  assign if1.start = start;  assign if1.a = a;  assign if1.b = b;  assign if1.cin = cin;
  assign if2.start = start;  assign if2.a = a;  assign if2.b = b;  assign if2.cin = cin;
  assign if4.start = start;  assign if4.a = a;  assign if4.b = b;  assign if4.cin = cin;
  assign if8.start = start;  assign if8.a = a;  assign if8.b = b;  assign if8.cin = cin;

  logic         dn [NI];
  logic         bs [NI];
  logic [W-1:0] sm [NI];
  logic         co [NI];
  logic         ov [NI];

  assign dn[0] = if1.done;  assign bs[0] = if1.busy;  assign sm[0] = if1.sum;
  assign co[0] = if1.cout;  assign ov[0] = if1.overflow;
  assign dn[1] = if2.done;  assign bs[1] = if2.busy;  assign sm[1] = if2.sum;
  assign co[1] = if2.cout;  assign ov[1] = if2.overflow;
  assign dn[2] = if4.done;  assign bs[2] = if4.busy;  assign sm[2] = if4.sum;
  assign co[2] = if4.cout;  assign ov[2] = if4.overflow;
  assign dn[3] = if8.done;  assign bs[3] = if8.busy;  assign sm[3] = if8.sum;
  assign co[3] = if8.cout;  assign ov[3] = if8.overflow;

  int           lat   [NI];
  logic [W-1:0] res_s [NI];
  logic         res_c [NI];
  logic         res_o [NI];
  logic [W-1:0] prev  [NI];

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (DIGIT=%0d): observed %0h expected %0h", tag, 1 << idx, obs, exp);
    end
  endtask

  // Reference: {overflow, cout, sum} straight from integer addition.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {o, t};
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < NI; i++) check("busy_after_accept", i, 32'(bs[i]), 32'd1);
  endtask

  task automatic collect();
    bit got [NI];
    for (int i = 0; i < NI; i++) begin got[i] = 1'b0; lat[i] = -1; end
    for (int cyc = 1; cyc <= MAXLAT + 1; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (got[i]) begin
          check("done_one_cycle", i, 32'(dn[i]), 32'd0);
        end else if (dn[i]) begin
          got[i]   = 1'b1;
          lat[i]   = cyc;
          res_s[i] = sm[i];
          res_c[i] = co[i];
          res_o[i] = ov[i];
          check("busy_at_done", i, 32'(bs[i]), 32'd0);
        end else if (bs[i]) begin
          check("sum_hold_busy", i, 32'(sm[i]), 32'(prev[i]));
        end
      end
    end
    for (int i = 0; i < NI; i++) check("done_seen", i, 32'(got[i]), 32'd1);
  endtask

  task automatic verify(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W+1:0] m;
    m = model(x, y, c);
    for (int i = 0; i < NI; i++) begin
      check("latency", i, 32'(lat[i]), 32'(MAXLAT >> i));
      check("sum", i, 32'(res_s[i]), 32'(m[W-1:0]));
      check("cout", i, 32'(res_c[i]), 32'(m[W]));
      check("overflow", i, 32'(res_o[i]), 32'(m[W+1]));
      prev[i] = m[W-1:0];
    end
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    launch(x, y, c);
    collect();
    verify(x, y, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first;
    int  second;
    bit  got0;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < NI; i++) prev[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_busy", i, 32'(bs[i]), 32'd0);
      check("reset_done", i, 32'(dn[i]), 32'd0);
      check("reset_sum", i, 32'(sm[i]), 32'd0);
      check("reset_cout", i, 32'(co[i]), 32'd0);
      check("reset_ovf", i, 32'(ov[i]), 32'd0);
    end
    reset = 1'b0;

    // Directed vectors; the first is accepted on the first edge after reset.
    run(8'h00, 8'h00, 1'b0);
    run(8'hFF, 8'h01, 1'b0);
    run(8'h7F, 8'h01, 1'b0);
    run(8'h80, 8'h80, 1'b0);
    run(8'hA5, 8'h5A, 1'b1);
    run(8'h9C, 8'h6B, 1'b0);

    // Start re-asserted mid-operation with other operands (DIGIT=1 build).
    launch(8'h12, 8'h34, 1'b0);
    got0 = 1'b0;
    for (int cyc = 1; cyc <= MAXLAT + 1; cyc++) begin
      if (cyc == 3) begin start = 1'b1; a = 8'hF0; b = 8'hF0; cin = 1'b1; end
      if (cyc == 6) start = 1'b0;
      @(posedge clk); #1;
      if (!got0 && dn[0]) begin
        got0 = 1'b1;
        check("restart_latency", 0, 32'(cyc), 32'(MAXLAT));
        check("restart_sum", 0, 32'(sm[0]), 32'h46);
      end else if (!got0 && bs[0]) begin
        check("restart_hold", 0, 32'(sm[0]), 32'(prev[0]));
      end
    end
    check("restart_done_seen", 0, 32'(got0), 32'd1);
    check("restart_no_queue", 0, 32'(bs[0]), 32'd0);

    // Start held high through done: back-to-back operations (DIGIT=1 build).
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    first = -1; second = -1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      if (dn[0]) begin
        if (first < 0) begin
          first = cyc;
          check("b2b_first_sum", 0, 32'(sm[0]), 32'h33);
          a = 8'h05; b = 8'h06;
        end else if (second < 0) begin
          second = cyc;
          check("b2b_second_sum", 0, 32'(sm[0]), 32'h0B);
          start = 1'b0;
        end
      end else if (bs[0] && first >= 0 && second < 0) begin
        check("b2b_hold", 0, 32'(sm[0]), 32'h33);
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 0, 32'(first), 32'(MAXLAT + 1));
    check("b2b_spacing", 0, 32'(second - first), 32'(MAXLAT + 1));

    // Reset during step 4 aborts the operation with no done pulse.
    launch(8'hFF, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("abort_busy", i, 32'(bs[i]), 32'd0);
      check("abort_done", i, 32'(dn[i]), 32'd0);
      check("abort_sum", i, 32'(sm[i]), 32'd0);
      check("abort_cout", i, 32'(co[i]), 32'd0);
      check("abort_ovf", i, 32'(ov[i]), 32'd0);
      prev[i] = '0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int cyc = 1; cyc <= MAXLAT + 2; cyc++) begin
      @(posedge clk); #1;
      check("abort_no_done", 0, 32'(dn[0]), 32'd0);
    end
    run(8'h03, 8'h04, 1'b0);

    // Random regression across all four digit sizes.
    for (int n = 0; n < 1000; n++) begin
      run(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
